// File: rtl/jfg_pkg.sv
// Shared types, text layout constants and glyph lookup for the joystick frame generator.
// Optional macro JFG_IDLE_TEXT_EN draws "IDLE" when no direction is active.
package jfg_pkg;

    localparam int FRAME_CHARS = 64;
    localparam int FRAME_BITS  = FRAME_CHARS * 8;
    localparam logic [7:0] SPACE = 8'h20;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int UP_START    = 7;
    localparam int LEFT_START  = 16;
    localparam int IDLE_START  = 38;
    localparam int RIGHT_START = 43;
    localparam int DOWN_START  = 54;

    localparam logic [23:0] UP_TEXT    = "TOP";
    localparam logic [39:0] LEFT_TEXT  = "SIDE1";
    localparam logic [39:0] RIGHT_TEXT = "SIDE2";
    localparam logic [31:0] DOWN_TEXT  = "DOWN";
    localparam logic [31:0] IDLE_TEXT  = "IDLE";

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUILD,
        ST_PUBLISH,
        ST_HOLD
    } jfg_state_t;

    // Character at byte index idx of the frame for direction set dir.
    // Text regions never overlap, so the checks can be applied in any order.
    function automatic logic [7:0] glyph(input logic [3:0] dir, input logic [5:0] idx);
        int i;
        logic [7:0] c;
        i = int'(idx);
        c = SPACE;
        if (dir[DIR_UP] && i >= UP_START && i < UP_START + 3)
            c = UP_TEXT[8*(UP_START + 2 - i) +: 8];
        if (dir[DIR_LEFT] && i >= LEFT_START && i < LEFT_START + 5)
            c = LEFT_TEXT[8*(LEFT_START + 4 - i) +: 8];
        if (dir[DIR_RIGHT] && i >= RIGHT_START && i < RIGHT_START + 5)
            c = RIGHT_TEXT[8*(RIGHT_START + 4 - i) +: 8];
        if (dir[DIR_DOWN] && i >= DOWN_START && i < DOWN_START + 4)
            c = DOWN_TEXT[8*(DOWN_START + 3 - i) +: 8];
`ifdef JFG_IDLE_TEXT_EN
        if (dir == 4'd0 && i >= IDLE_START && i < IDLE_START + 4)
            c = IDLE_TEXT[8*(IDLE_START + 3 - i) +: 8];
`endif
        return c;
    endfunction

endpackage

// File: rtl/joystick_frame_gen_if.sv
// Frame hand-off between the frame generator (master) and the OLED byte sequencer (slave).
interface joystick_frame_gen_if;
    import jfg_pkg::*;

    logic [FRAME_BITS-1:0] frame;
    logic                  frame_update;
    logic                  consumer_ready;

    modport master (output frame, output frame_update, input consumer_ready);
    modport slave  (input frame, input frame_update, output consumer_ready);
endinterface

// File: rtl/jfg_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one raw button.
module jfg_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            // Counter holds the number of consecutive samples disagreeing with stable_reg.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign stable = stable_reg;
endmodule

// File: rtl/joystick_frame_gen.sv
// Debounces four direction buttons and publishes a 4x16 ASCII frame on each change, rate-limited.
// Optional macro JFG_IDLE_TEXT_EN (see jfg_pkg) adds "IDLE" text for an empty direction set.
module joystick_frame_gen
    import jfg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MIN_HOLD_CYCLES = 10000000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_left,
    input  logic                       btn_right,
    output logic [3:0]                 direction,
    joystick_frame_gen_if.master       frame_bus
);
    localparam int IW = $clog2(FRAME_CHARS);
    localparam int HW = $clog2(MIN_HOLD_CYCLES + 1);

    logic [3:0]            btn_raw;
    jfg_state_t            state_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic                  frame_update_reg;
    logic [3:0]            snap_reg;
    logic [3:0]            last_pub_reg;
    logic [IW-1:0]         char_idx_reg;
    logic [HW-1:0]         hold_cnt_reg;
    logic                  pending_reg;
    logic [7:0]            shadow_mem [FRAME_CHARS];
    logic [FRAME_BITS-1:0] shadow_flat;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            jfg_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock   (clock),
                .reset_n (reset_n),
                .raw     (btn_raw[gi]),
                .stable  (direction[gi])
            );
        end
        for (gi = 0; gi < FRAME_CHARS; gi++) begin : g_flatten
            assign shadow_flat[FRAME_BITS-1-8*gi -: 8] = shadow_mem[gi];
        end
    endgenerate

    // Shadow buffer is fully rewritten before every publish, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state_reg == ST_BUILD)
            shadow_mem[char_idx_reg] <= glyph(snap_reg, char_idx_reg);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            frame_reg        <= {FRAME_CHARS{SPACE}};
            frame_update_reg <= 1'b0;
            snap_reg         <= '0;
            last_pub_reg     <= '0;
            char_idx_reg     <= '0;
            hold_cnt_reg     <= '0;
            pending_reg      <= 1'b1;
        end else begin
            frame_update_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pending_reg || direction != last_pub_reg) begin
                        snap_reg     <= direction;
                        char_idx_reg <= '0;
                        pending_reg  <= 1'b0;
                        state_reg    <= ST_BUILD;
                    end
                end
                ST_BUILD: begin
                    if (char_idx_reg == IW'(FRAME_CHARS - 1))
                        state_reg <= ST_PUBLISH;
                    else
                        char_idx_reg <= char_idx_reg + 1'b1;
                end
                ST_PUBLISH: begin
                    if (frame_bus.consumer_ready) begin
                        frame_reg        <= shadow_flat;
                        frame_update_reg <= 1'b1;
                        last_pub_reg     <= snap_reg;
                        hold_cnt_reg     <= '0;
                        state_reg        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_reg == HW'(MIN_HOLD_CYCLES - 1))
                        state_reg <= ST_IDLE;
                    else
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign frame_bus.frame        = frame_reg;
    assign frame_bus.frame_update = frame_update_reg;
endmodule

// File: tb/tb_joystick_frame_gen.sv
// Self-checking bench for joystick_frame_gen: directed scenarios plus randomized button/ready traffic.
module tb_joystick_frame_gen;
    import jfg_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] btns;
    logic [3:0] direction;
    logic       ready;

    joystick_frame_gen_if fbus ();
    assign fbus.consumer_ready = ready;

    joystick_frame_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .MIN_HOLD_CYCLES(HOLD)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_up    (btns[3]),
        .btn_down  (btns[2]),
        .btn_left  (btns[1]),
        .btn_right (btns[0]),
        .direction (direction),
        .frame_bus (fbus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [FRAME_BITS-1:0] obs, input logic [FRAME_BITS-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame built directly from the text layout table.
    function automatic logic [FRAME_BITS-1:0] exp_frame(input logic [3:0] d);
        string txt [4];
        int    pos [4];
        string idle_txt;
        logic [7:0] b [64];
        logic [FRAME_BITS-1:0] f;
        txt = '{"SIDE2", "SIDE1", "DOWN", "TOP"};
        pos = '{43, 16, 54, 7};
        idle_txt = "IDLE";
        for (int i = 0; i < 64; i++) b[i] = 8'h20;
        for (int k = 0; k < 4; k++)
            if (d[k])
                for (int j = 0; j < txt[k].len(); j++) b[pos[k] + j] = txt[k][j];
`ifdef JFG_IDLE_TEXT_EN
        if (d == 4'd0)
            for (int j = 0; j < idle_txt.len(); j++) b[38 + j] = idle_txt[j];
`endif
        for (int i = 0; i < 64; i++) f[FRAME_BITS-1-8*i -: 8] = b[i];
        return f;
    endfunction

    // Debounce reference: a button's debounced value takes the synchronised level once
    // that level has persisted for DEB consecutive samples.
    logic [3:0] m_dir;
    logic [3:0] raw_d1, raw_d2, run_val;
    int         run_len [4];
    initial forever begin
        logic [3:0] s;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            raw_d1 = '0; raw_d2 = '0; run_val = '0; m_dir = '0;
            for (int i = 0; i < 4; i++) run_len[i] = 0;
        end else begin
            s = raw_d2;
            raw_d2 = raw_d1;
            raw_d1 = btns;
            for (int i = 0; i < 4; i++) begin
                if (s[i] == run_val[i]) run_len[i]++;
                else begin run_val[i] = s[i]; run_len[i] = 1; end
                if (run_val[i] != m_dir[i] && run_len[i] >= DEB) m_dir[i] = run_val[i];
            end
        end
    end

    int cycle = 0;
    initial forever begin
        @(posedge clock);
        cycle++;
    end

    // Publication monitor: direction tracking, pulse spacing, frame stability between pulses.
    int pulse_cnt = 0;
    int last_pulse_cycle = 0;
    bit have_pulse = 0;
    logic [FRAME_BITS-1:0] last_frame;
    logic [FRAME_BITS-1:0] prev_frame;
    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            chk("direction", {508'd0, direction}, {508'd0, m_dir});
            if (fbus.frame_update) begin
                pulse_cnt++;
                if (have_pulse)
                    chk("pulse_spacing", FRAME_BITS'(cycle - last_pulse_cycle >= HOLD + 66), FRAME_BITS'(1));
                have_pulse = 1;
                last_pulse_cycle = cycle;
                last_frame = fbus.frame;
                $display("frame %0d published at cycle %0d, direction %b", pulse_cnt, cycle, direction);
            end else begin
                chk("frame_stable", fbus.frame, prev_frame);
            end
        end else begin
            have_pulse = 0;
        end
        prev_frame = fbus.frame;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_BITS-1:0] spaces;
        int n, p0;
        bit seen;
        logic [3:0] b;
        spaces = {FRAME_CHARS{8'h20}};
        reset_n = 1'b0;
        ready = 1'b1;
        btns = '0;
        cycles(3);
        chk("rst_frame_update", FRAME_BITS'(fbus.frame_update), FRAME_BITS'(0));
        chk("rst_frame", fbus.frame, spaces);
        chk("rst_direction", FRAME_BITS'(direction), FRAME_BITS'(0));
        chk("rst_state", FRAME_BITS'(dut.state_reg), FRAME_BITS'(ST_IDLE));

        // Initial frame forced by reset.
        reset_n = 1'b1;
        n = 0; seen = 0;
        while (n < 100 && !seen) begin
            @(negedge clock);
            n++;
            seen = fbus.frame_update;
        end
        chk("first_seen", FRAME_BITS'(seen), FRAME_BITS'(1));
        chk("first_latency", FRAME_BITS'(n), FRAME_BITS'(66));
        chk("first_frame", fbus.frame, exp_frame(4'd0));
        cycles(1);
        p0 = pulse_cnt;
        cycles(150);
        chk("no_extra_pulse", FRAME_BITS'(pulse_cnt), FRAME_BITS'(p0));

        // Single direction.
        btns = 4'b1000;
        n = 0;
        while (n < 20 && direction != 4'b1000) begin
            @(negedge clock);
            n++;
        end
        chk("up_latency", FRAME_BITS'(n), FRAME_BITS'(DEB + 2));
        n = 0; seen = 0;
        while (n < 200 && !seen) begin
            @(negedge clock);
            n++;
            seen = fbus.frame_update;
        end
        chk("up_pulse", FRAME_BITS'(seen), FRAME_BITS'(1));
        chk("up_frame", fbus.frame, exp_frame(4'b1000));
        btns = 4'b0000;
        cycles(200);
        chk("release_frame", last_frame, exp_frame(4'b0000));

        // Opposing directions together.
        btns = 4'b0011;
        cycles(200);
        chk("lr_direction", FRAME_BITS'(direction), FRAME_BITS'(4'b0011));
        chk("lr_frame", last_frame, exp_frame(4'b0011));
        btns = 4'b0000;
        cycles(200);

        // Short glitch must be ignored.
        p0 = pulse_cnt;
        btns[2] = 1'b1;
        cycles(3);
        btns[2] = 1'b0;
        cycles(100);
        chk("glitch_direction", FRAME_BITS'(direction), FRAME_BITS'(0));
        chk("glitch_pulses", FRAME_BITS'(pulse_cnt), FRAME_BITS'(p0));

        // Consumer not ready: frame waits in PUBLISH.
        ready = 1'b0;
        p0 = pulse_cnt;
        btns = 4'b1000;
        cycles(200);
        chk("nr_pulses", FRAME_BITS'(pulse_cnt), FRAME_BITS'(p0));
        chk("nr_frame_old", fbus.frame, exp_frame(4'b0000));
        ready = 1'b1;
        @(negedge clock);
        chk("nr_update", FRAME_BITS'(fbus.frame_update), FRAME_BITS'(1));
        chk("nr_frame_new", fbus.frame, exp_frame(4'b1000));
        cycles(100);

        // Asynchronous reset in the middle of BUILD.
        btns = 4'b1001;
        n = 0;
        while (n < 50 && !(dut.state_reg == ST_BUILD && dut.char_idx_reg == 6'd30)) begin
            @(negedge clock);
            n++;
        end
        chk("build_reached", FRAME_BITS'(n < 50), FRAME_BITS'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_frame_update", FRAME_BITS'(fbus.frame_update), FRAME_BITS'(0));
        chk("ar_frame", fbus.frame, spaces);
        chk("ar_state", FRAME_BITS'(dut.state_reg), FRAME_BITS'(ST_IDLE));
        cycles(3);
        p0 = pulse_cnt;
        reset_n = 1'b1;
        cycles(300);
        chk("ar_republish", FRAME_BITS'(pulse_cnt > p0), FRAME_BITS'(1));
        chk("ar_final_frame", last_frame, exp_frame(4'b1001));

        // Randomized button sets, glitches and consumer back-pressure.
        for (int it = 0; it < 12; it++) begin
            int g;
            b = 4'($urandom_range(0, 15));
            btns = b;
            cycles($urandom_range(10, 40));
            g = $urandom_range(0, 3);
            btns[g] = ~btns[g];
            cycles($urandom_range(1, DEB - 1));
            btns = b;
            for (int c = 0; c < 150; c++) begin
                ready = 1'($urandom_range(0, 1));
                @(negedge clock);
            end
            ready = 1'b1;
            cycles(200);
            chk("rand_direction", FRAME_BITS'(direction), FRAME_BITS'(b));
            chk("rand_frame", last_frame, exp_frame(b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
